// File: rtl/kb_ascii_fifo_if.sv
// kb_ascii_fifo_if: scan-code input, FIFO read and status bundle for the keyboard ASCII FIFO
interface kb_ascii_fifo_if #(parameter int ADDR_W = 3);
    logic [7:0]      scan_code;
    logic            scan_valid;
    logic            rd;
    logic [7:0]      ascii_out;
    logic            empty;
    logic            full;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic            shift_active;
    modport master (output scan_code, scan_valid, rd,
                    input  ascii_out, empty, full, count, overflow, shift_active);
    modport slave  (input  scan_code, scan_valid, rd,
                    output ascii_out, empty, full, count, overflow, shift_active);
endinterface

// File: rtl/kb_ascii_fifo.sv
// kb_ascii_fifo: PS/2 set-2 scan codes to ASCII with prefix/shift tracking, buffered in a show-ahead FIFO
module kb_ascii_fifo #(
    parameter int         ADDR_W        = 3,
    parameter logic [7:0] ERR_CHAR      = 8'h2A,
    parameter bit         PUSH_UNMAPPED = 1'b1
) (
    input logic             clk,
    input logic             reset_n,
    kb_ascii_fifo_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
    state_t          state, state_nx;
    logic            shift_l, shift_r, shift_l_nx, shift_r_nx;
    logic [7:0]      ch, dec, push_data;
    logic            hit, push, do_rd, do_wr;
    logic [7:0]      mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] wp, rp;
    logic [ADDR_W:0] cnt;
    logic            ovf;
    assign bus.shift_active = shift_l | shift_r;
    assign bus.count        = cnt;
    assign bus.empty        = cnt == '0;
    assign bus.full         = cnt[ADDR_W];
    assign bus.overflow     = ovf;
    assign bus.ascii_out    = bus.empty ? 8'h00 : mem[rp];
    assign dec   = (ch >= 8'h61 && ch <= 8'h7A && bus.shift_active) ? ch - 8'h20 : ch;
    assign do_rd = bus.rd && !bus.empty;
    assign do_wr = push && (!bus.full || do_rd);
    // Make-code lookup; letters come out lowercase and are lifted when shift is held
    always_comb begin
        hit = 1'b1;
        ch  = ERR_CHAR;
        case (bus.scan_code)
            8'h45: ch = 8'h30;
            8'h16: ch = 8'h31;
            8'h1E: ch = 8'h32;
            8'h26: ch = 8'h33;
            8'h25: ch = 8'h34;
            8'h2E: ch = 8'h35;
            8'h36: ch = 8'h36;
            8'h3D: ch = 8'h37;
            8'h3E: ch = 8'h38;
            8'h46: ch = 8'h39;
            8'h1C: ch = 8'h61;
            8'h32: ch = 8'h62;
            8'h21: ch = 8'h63;
            8'h23: ch = 8'h64;
            8'h24: ch = 8'h65;
            8'h2B: ch = 8'h66;
            8'h34: ch = 8'h67;
            8'h33: ch = 8'h68;
            8'h43: ch = 8'h69;
            8'h3B: ch = 8'h6A;
            8'h42: ch = 8'h6B;
            8'h4B: ch = 8'h6C;
            8'h3A: ch = 8'h6D;
            8'h31: ch = 8'h6E;
            8'h44: ch = 8'h6F;
            8'h4D: ch = 8'h70;
            8'h15: ch = 8'h71;
            8'h2D: ch = 8'h72;
            8'h1B: ch = 8'h73;
            8'h2C: ch = 8'h74;
            8'h3C: ch = 8'h75;
            8'h2A: ch = 8'h76;
            8'h1D: ch = 8'h77;
            8'h22: ch = 8'h78;
            8'h35: ch = 8'h79;
            8'h1A: ch = 8'h7A;
            8'h29: ch = 8'h20;
            8'h66: ch = 8'h08;
            8'h5A: ch = 8'h0D;
            default: hit = 1'b0;
        endcase
    end
    // Prefix FSM: tracks break/extended prefixes and shift keys, decides what gets pushed
    always_comb begin
        state_nx   = state;
        shift_l_nx = shift_l;
        shift_r_nx = shift_r;
        push       = 1'b0;
        push_data  = dec;
        if (bus.scan_valid) begin
            case (state)
                IDLE: begin
                    if (bus.scan_code == 8'hF0) state_nx = BRK;
                    else if (bus.scan_code == 8'hE0) state_nx = EXT;
                    else if (bus.scan_code == 8'h12) shift_l_nx = 1'b1;
                    else if (bus.scan_code == 8'h59) shift_r_nx = 1'b1;
                    else push = hit || PUSH_UNMAPPED;
                end
                BRK: begin
                    shift_l_nx = (bus.scan_code == 8'h12) ? 1'b0 : shift_l;
                    shift_r_nx = (bus.scan_code == 8'h59) ? 1'b0 : shift_r;
                    state_nx   = IDLE;
                end
                EXT: begin
                    state_nx  = (bus.scan_code == 8'hF0) ? EXT_BRK : IDLE;
                    push      = bus.scan_code == 8'h5A;
                    push_data = 8'h0D;
                end
                default: state_nx = IDLE;
            endcase
        end
    end
    // Control state, pointers, occupancy and the one-cycle overflow pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            shift_l <= 1'b0;
            shift_r <= 1'b0;
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nx;
            shift_l <= shift_l_nx;
            shift_r <= shift_r_nx;
            wp      <= do_wr ? wp + 1'b1 : wp;
            rp      <= do_rd ? rp + 1'b1 : rp;
            cnt     <= cnt + {{ADDR_W{1'b0}}, do_wr} - {{ADDR_W{1'b0}}, do_rd};
            ovf     <= push && bus.full && !do_rd;
        end
    end
    // Character storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= push_data;
    end
endmodule

// File: tb/tb_kb_ascii_fifo.sv
// tb_kb_ascii_fifo: table vectors plus hand sequences, checked against a queue scoreboard
module tb_kb_ascii_fifo;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;
    kb_ascii_fifo_if #(.ADDR_W(3)) bus ();
    kb_ascii_fifo_if #(.ADDR_W(3)) bus0 ();
    kb_ascii_fifo #(.ADDR_W(3)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    kb_ascii_fifo #(.ADDR_W(3), .PUSH_UNMAPPED(1'b0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
    typedef struct {
        logic [7:0] code;
        bit         p;
        logic [7:0] ch;
    } vec_t;
    vec_t vt[14];
    int total = 0;
    int bad = 0;
    logic [7:0] q[$];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    task automatic send(input logic [7:0] c, input bit p, input logic [7:0] ch);
        bit ov = p && (q.size() == 8);
        if (p && !ov) q.push_back(ch);
        bus.scan_code = c;
        bus.scan_valid = 1'b1;
        @(negedge clk);
        bus.scan_valid = 1'b0;
        chk("count", bus.count, q.size());
        chk("overflow", bus.overflow, ov);
    endtask
    task automatic push_pop(input logic [7:0] c, input logic [7:0] ch);
        if (q.size() > 0) begin
            chk("pp_head", bus.ascii_out, q[0]);
            void'(q.pop_front());
        end
        q.push_back(ch);
        bus.scan_code = c;
        bus.scan_valid = 1'b1;
        bus.rd = 1'b1;
        @(negedge clk);
        bus.scan_valid = 1'b0;
        bus.rd = 1'b0;
        chk("pp_count", bus.count, q.size());
        chk("pp_overflow", bus.overflow, 0);
    endtask
    task automatic pop();
        chk("empty", bus.empty, q.size() == 0);
        if (q.size() > 0) begin
            chk("head", bus.ascii_out, q[0]);
            void'(q.pop_front());
        end
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
        chk("pop_count", bus.count, q.size());
    endtask
    task automatic drain();
        while (q.size() > 0) pop();
    endtask
    initial begin
        vt[0]  = '{8'h16, 1'b1, 8'h31};
        vt[1]  = '{8'hF0, 1'b0, 8'h00};
        vt[2]  = '{8'h16, 1'b0, 8'h00};
        vt[3]  = '{8'hE0, 1'b0, 8'h00};
        vt[4]  = '{8'h5A, 1'b1, 8'h0D};
        vt[5]  = '{8'hE0, 1'b0, 8'h00};
        vt[6]  = '{8'hF0, 1'b0, 8'h00};
        vt[7]  = '{8'h5A, 1'b0, 8'h00};
        vt[8]  = '{8'hE0, 1'b0, 8'h00};
        vt[9]  = '{8'h75, 1'b0, 8'h00};
        vt[10] = '{8'h45, 1'b1, 8'h30};
        vt[11] = '{8'h29, 1'b1, 8'h20};
        vt[12] = '{8'h66, 1'b1, 8'h08};
        vt[13] = '{8'h1A, 1'b1, 8'h7A};
        bus.scan_code = 8'h00;
        bus.scan_valid = 1'b0;
        bus.rd = 1'b0;
        bus0.scan_code = 8'h00;
        bus0.scan_valid = 1'b0;
        bus0.rd = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_ascii", bus.ascii_out, 8'h00);
        chk("rst_shift", bus.shift_active, 0);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            send(vt[i].code, vt[i].p, vt[i].ch);
            if (q.size() >= 3) drain();
        end
        drain();
        send(8'h12, 1'b0, 8'h00);
        chk("shift_l_on", bus.shift_active, 1);
        send(8'h1C, 1'b1, 8'h41);
        send(8'hF0, 1'b0, 8'h00);
        chk("shift_mid_brk", bus.shift_active, 1);
        send(8'h12, 1'b0, 8'h00);
        chk("shift_l_off", bus.shift_active, 0);
        send(8'h1C, 1'b1, 8'h61);
        send(8'h59, 1'b0, 8'h00);
        chk("shift_r_on", bus.shift_active, 1);
        send(8'h15, 1'b1, 8'h51);
        send(8'hF0, 1'b0, 8'h00);
        send(8'h59, 1'b0, 8'h00);
        chk("shift_r_off", bus.shift_active, 0);
        send(8'h4D, 1'b1, 8'h70);
        drain();
        send(8'h16, 1'b1, 8'h31);
        send(8'h1E, 1'b1, 8'h32);
        send(8'h26, 1'b1, 8'h33);
        send(8'h25, 1'b1, 8'h34);
        send(8'h2E, 1'b1, 8'h35);
        send(8'h36, 1'b1, 8'h36);
        send(8'h3D, 1'b1, 8'h37);
        send(8'h3E, 1'b1, 8'h38);
        chk("full_at_8", bus.full, 1);
        send(8'h46, 1'b1, 8'h39);
        chk("full_after_drop", bus.full, 1);
        @(negedge clk);
        chk("overflow_one_cycle", bus.overflow, 0);
        push_pop(8'h45, 8'h30);
        chk("full_after_pp", bus.full, 1);
        drain();
        push_pop(8'h29, 8'h20);
        push_pop(8'h66, 8'h08);
        drain();
        send(8'h07, 1'b1, 8'h2A);
        drain();
        bus0.scan_code = 8'h07;
        bus0.scan_valid = 1'b1;
        @(negedge clk);
        bus0.scan_valid = 1'b0;
        chk("nopush_count", bus0.count, 0);
        chk("nopush_empty", bus0.empty, 1);
        bus0.scan_code = 8'h1C;
        bus0.scan_valid = 1'b1;
        @(negedge clk);
        bus0.scan_valid = 1'b0;
        chk("dut0_count", bus0.count, 1);
        chk("dut0_head", bus0.ascii_out, 8'h61);
        pop();
        pop();
        send(8'h32, 1'b1, 8'h62);
        drain();
        send(8'h21, 1'b1, 8'h63);
        send(8'h23, 1'b1, 8'h64);
        send(8'h24, 1'b1, 8'h65);
        send(8'h12, 1'b0, 8'h00);
        send(8'hF0, 1'b0, 8'h00);
        reset_n = 1'b0;
        @(negedge clk);
        q.delete();
        chk("arst_count", bus.count, 0);
        chk("arst_empty", bus.empty, 1);
        chk("arst_shift", bus.shift_active, 0);
        reset_n = 1'b1;
        @(negedge clk);
        send(8'h16, 1'b1, 8'h31);
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
